// File: rtl/serial_link_rx_fifo_pkg.sv
// Shared types, register map and FSM states for serial_link_rx_fifo.
// Default AXI/OBI structs use 4-bit IDs and 32-bit data.
package serial_link_rx_fifo_pkg;

  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;

  localparam logic [3:0] DATA_OFFSET   = 4'h0;
  localparam logic [3:0] STATUS_OFFSET = 4'h4;
  localparam logic [3:0] THRESH_OFFSET = 4'h8;
  localparam logic [3:0] CTRL_OFFSET   = 4'hC;

  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_UDF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  localparam int unsigned CTRL_FLUSH = 0;
  localparam int unsigned CTRL_CLR   = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } sl_axi_ax_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
  } sl_axi_w_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    logic [1:0]        resp;
  } sl_axi_b_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } sl_axi_r_t;

  typedef struct packed {
    sl_axi_ax_t aw;
    logic       aw_valid;
    sl_axi_w_t  w;
    logic       w_valid;
    logic       b_ready;
    sl_axi_ax_t ar;
    logic       ar_valid;
    logic       r_ready;
  } sl_axi_req_t;

  typedef struct packed {
    logic      aw_ready;
    logic      ar_ready;
    logic      w_ready;
    logic      b_valid;
    sl_axi_b_t b;
    logic      r_valid;
    sl_axi_r_t r;
  } sl_axi_rsp_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sl_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } sl_obi_rsp_t;

endpackage

// File: rtl/serial_link_rx_fifo_mem.sv
// Synchronous FIFO storage for serial_link_rx_fifo.
// Flush has priority over push and pop; pointers wrap modulo depth.
module sl_rx_fifo_mem
  import serial_link_rx_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic                 i_flush,
  input  logic [DataWidth-1:0] i_wdata,
  output logic [DataWidth-1:0] o_rdata,
  output logic [7:0]           o_count,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);

  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [7:0]           r_count;
  logic                 w_push;
  logic                 w_pop;

  function automatic logic [PtrW-1:0] f_inc(
    input logic [PtrW-1:0] p
  );
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign o_count = r_count;
  assign o_empty = (r_count == 8'd0);
  assign o_full  = (r_count == 8'(FifoDepth));
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop) r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_link_rx_fifo.sv
// AXI4 write sink buffering W beats for CPU readout over OBI.
// Define SL_RX_FIFO_DROP_EN to drop beats when full instead of stalling W.
module serial_link_rx_fifo
  import serial_link_rx_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 8,
  parameter type axi_req_t  = sl_axi_req_t,
  parameter type axi_rsp_t  = sl_axi_rsp_t,
  parameter type obi_req_t  = sl_obi_req_t,
  parameter type obi_resp_t = sl_obi_rsp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  axi_req_i,
  output axi_rsp_t  axi_rsp_o,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_rsp_o,
  output logic      fifo_empty_o,
  output logic      fifo_full_o,
  output logic      level_irq_o
);

  wr_state_e            r_wstate;
  rd_state_e            r_rstate;
  axi_req_t             r_aw;
  axi_req_t             r_ar;
  logic                 r_wdrop;
  logic [7:0]           r_rcnt;
  logic [7:0]           r_thresh;
  logic                 r_ovf;
  logic                 r_udf;
  logic                 r_irq;
  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;

  logic                 w_empty;
  logic                 w_full;
  logic [7:0]           w_count;
  logic [DataWidth-1:0] w_head;
  logic                 w_wready;
  logic                 w_whs;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_rlast;
  logic                 w_gnt;
  logic                 w_rd;
  logic                 w_wr;
  logic [3:0]           w_addr;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_clr;
  logic                 w_udf_set;
  logic                 w_thr_we;
  logic [DataWidth-1:0] w_rdata_nxt;
  logic [DataWidth-1:0] w_status;
  logic                 w_unused;

  sl_rx_fifo_mem #(
    .DataWidth(DataWidth),
    .FifoDepth(FifoDepth)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(w_flush),
    .i_wdata(axi_req_i.w.data),
    .o_rdata(w_head),
    .o_count(w_count),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  assign w_whs = (r_wstate == W_DATA)
               & axi_req_i.w_valid & w_wready;

`ifdef SL_RX_FIFO_DROP_EN
  assign w_wready = (r_wstate == W_DATA);
  assign w_drop   = w_whs & w_full & ~w_flush;
`else
  assign w_wready = (r_wstate == W_DATA) & ~w_full;
  assign w_drop   = 1'b0;
`endif

  assign w_push  = w_whs & ~w_full;
  assign w_rlast = (r_rcnt == r_ar.ar.len);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate <= W_IDLE;
      r_aw     <= '0;
      r_wdrop  <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: if (axi_req_i.aw_valid) begin
          r_aw     <= axi_req_i;
          r_wdrop  <= 1'b0;
          r_wstate <= W_DATA;
        end
        W_DATA: if (w_whs) begin
          if (w_drop) r_wdrop <= 1'b1;
          if (axi_req_i.w.last) r_wstate <= W_RESP;
        end
        W_RESP: if (axi_req_i.b_ready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_ar     <= '0;
      r_rcnt   <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: if (axi_req_i.ar_valid) begin
          r_ar     <= axi_req_i;
          r_rcnt   <= '0;
          r_rstate <= R_BURST;
        end
        R_BURST: if (axi_req_i.r_ready) begin
          if (w_rlast) r_rstate <= R_IDLE;
          else r_rcnt <= r_rcnt + 8'd1;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = (r_wstate == W_IDLE);
    axi_rsp_o.w_ready  = w_wready;
    axi_rsp_o.b_valid  = (r_wstate == W_RESP);
    axi_rsp_o.b.id     = r_aw.aw.id;
    axi_rsp_o.b.resp   = r_wdrop ? RESP_SLVERR
                                 : RESP_OKAY;
    axi_rsp_o.ar_ready = (r_rstate == R_IDLE);
    axi_rsp_o.r_valid  = (r_rstate == R_BURST);
    axi_rsp_o.r.id     = r_ar.ar.id;
    axi_rsp_o.r.resp   = RESP_SLVERR;
    axi_rsp_o.r.last   = w_rlast;
  end

  assign w_gnt  = obi_req_i.req & ~rst_i;
  assign w_rd   = w_gnt & ~obi_req_i.we;
  assign w_wr   = w_gnt & obi_req_i.we;
  assign w_addr = obi_req_i.addr[3:0];

  always_comb begin
    w_status                        = '0;
    w_status[STAT_EMPTY]            = w_empty;
    w_status[STAT_FULL]             = w_full;
    w_status[STAT_OVF]              = r_ovf;
    w_status[STAT_UDF]              = r_udf;
    w_status[STAT_CNT_LSB +: 8]     = w_count;
  end

  always_comb begin
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_clr       = 1'b0;
    w_udf_set   = 1'b0;
    w_thr_we    = 1'b0;
    w_rdata_nxt = '0;
    if (w_rd) begin
      unique case (1'b1)
        (w_addr == DATA_OFFSET): begin
          if (w_empty) begin
            w_udf_set = 1'b1;
          end else begin
            w_pop       = 1'b1;
            w_rdata_nxt = w_head;
          end
        end
        (w_addr == STATUS_OFFSET):
          w_rdata_nxt = w_status;
        (w_addr == THRESH_OFFSET):
          w_rdata_nxt = DataWidth'(r_thresh);
        default: w_rdata_nxt = '0;
      endcase
    end
    if (w_wr) begin
      unique case (1'b1)
        (w_addr == THRESH_OFFSET):
          w_thr_we = obi_req_i.be[0];
        (w_addr == CTRL_OFFSET): begin
          w_flush = obi_req_i.be[0]
                  & obi_req_i.wdata[CTRL_FLUSH];
          w_clr   = obi_req_i.be[0]
                  & obi_req_i.wdata[CTRL_CLR];
        end
        default: w_thr_we = 1'b0;
      endcase
    end
  end

  // Set wins over clear so a concurrent event is never lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_thresh <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) r_rdata <= w_rdata_nxt;
      if (w_thr_we) r_thresh <= obi_req_i.wdata[7:0];
      r_ovf <= (r_ovf & ~w_clr) | w_drop;
      r_udf <= (r_udf & ~w_clr) | w_udf_set;
      r_irq <= (w_count >= r_thresh)
             & (r_thresh != 8'd0);
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = w_gnt;
    obi_rsp_o.rvalid = r_rvalid;
    obi_rsp_o.rdata  = r_rdata;
  end

  assign fifo_empty_o = w_empty;
  assign fifo_full_o  = w_full;
  assign level_irq_o  = r_irq;

  assign w_unused = ^{axi_req_i, obi_req_i, r_aw, r_ar};

endmodule

// File: tb/tb_serial_link_rx_fifo.sv
// Scoreboard bench for serial_link_rx_fifo (default FifoDepth 8).
// Beats are queued on W handshake and compared on OBI DATA pops.
module tb_serial_link_rx_fifo;
  import serial_link_rx_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  sl_axi_req_t axi_req;
  sl_axi_rsp_t axi_rsp;
  sl_obi_req_t obi_req;
  sl_obi_rsp_t obi_rsp;
  logic        empty;
  logic        full;
  logic        irq;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  serial_link_rx_fifo #(
    .DataWidth(32),
    .FifoDepth(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .axi_req_i   (axi_req),
    .axi_rsp_o   (axi_rsp),
    .obi_req_i   (obi_req),
    .obi_rsp_o   (obi_rsp),
    .fifo_empty_o(empty),
    .fifo_full_o (full),
    .level_irq_o (irq)
  );

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, act, exp);
    end
  endtask

  task automatic axi_aw(input logic [3:0] id,
                        input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    axi_req.aw       = '0;
    axi_req.aw.id    = id;
    axi_req.aw.len   = len;
    axi_req.aw_valid = 1'b1;
    while (!axi_rsp.aw_ready && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) check("aw_timeout", 1, 0);
    @(posedge clk); #1;
    axi_req.aw_valid = 1'b0;
  endtask

  task automatic axi_w(input logic [31:0] d,
                       input logic last,
                       input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    axi_req.w.data  = d;
    axi_req.w.strb  = 4'hF;
    axi_req.w.last  = last;
    axi_req.w_valid = 1'b1;
    while (!axi_rsp.w_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("w_timeout", 1, 0);
    @(posedge clk);
`ifdef SL_RX_FIFO_DROP_EN
    if (keep && q.size() < DEPTH) q.push_back(d);
`else
    if (keep) q.push_back(d);
`endif
    #1;
    axi_req.w_valid = 1'b0;
  endtask

  task automatic axi_b(input logic [3:0] id,
                       input logic [1:0] resp);
    int n;
    n = 0;
    @(negedge clk);
    axi_req.b_ready = 1'b1;
    while (!axi_rsp.b_valid && n < 100) begin
      @(negedge clk); n++;
    end
    check("b_valid", axi_rsp.b_valid, 1);
    check("b_id", axi_rsp.b.id, id);
    check("b_resp", axi_rsp.b.resp, resp);
    @(posedge clk); #1;
    axi_req.b_ready = 1'b0;
  endtask

  task automatic obi_rd(input logic [3:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    obi_req.req   = 1'b1;
    obi_req.we    = 1'b0;
    obi_req.addr  = {28'h0, a};
    obi_req.be    = 4'hF;
    obi_req.wdata = '0;
    @(posedge clk);
    @(negedge clk);
    obi_req.req = 1'b0;
    check("obi_rvalid", obi_rsp.rvalid, 1);
    d = obi_rsp.rdata;
  endtask

  task automatic obi_wr(input logic [3:0] a,
                        input logic [31:0] v);
    @(negedge clk);
    obi_req.req   = 1'b1;
    obi_req.we    = 1'b1;
    obi_req.addr  = {28'h0, a};
    obi_req.be    = 4'hF;
    obi_req.wdata = v;
    @(posedge clk);
    @(negedge clk);
    obi_req.req = 1'b0;
    obi_req.we  = 1'b0;
    check("obi_wr_rvalid", obi_rsp.rvalid, 1);
    check("obi_wr_rdata", obi_rsp.rdata, 0);
  endtask

  task automatic obi_pop(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    obi_rd(DATA_OFFSET, d);
    e = (q.size() > 0) ? q.pop_front() : 32'h0;
    check(tag, d, e);
  endtask

  task automatic stat(input string tag,
                      input logic [31:0] e);
    logic [31:0] d;
    obi_rd(STATUS_OFFSET, d);
    check(tag, d, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    axi_req = '0;
    obi_req = '0;
    obi_req.req = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_aw_ready", axi_rsp.aw_ready, 1);
    check("rst_ar_ready", axi_rsp.ar_ready, 1);
    check("rst_w_ready", axi_rsp.w_ready, 0);
    check("rst_b_valid", axi_rsp.b_valid, 0);
    check("rst_r_valid", axi_rsp.r_valid, 0);
    check("rst_gnt", obi_rsp.gnt, 0);
    check("rst_rvalid", obi_rsp.rvalid, 0);
    check("rst_rdata", obi_rsp.rdata, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_irq", irq, 0);
    obi_req.req = 1'b0;
    rst = 1'b0;

    axi_aw(4'd1, 8'd3);
    for (int i = 0; i < 4; i++)
      axi_w(32'hA0 + i, i == 3, 1'b1);
    axi_b(4'd1, RESP_OKAY);
    for (int i = 0; i < 4; i++) obi_pop("t1_data");
    check("t1_empty", empty, 1);

`ifdef SL_RX_FIFO_DROP_EN
    axi_aw(4'd2, 8'd9);
    for (int i = 0; i < 10; i++)
      axi_w(32'hB0 + i, i == 9, 1'b1);
    axi_b(4'd2, RESP_SLVERR);
    stat("t2_status", 32'h806);
    for (int i = 0; i < 8; i++) obi_pop("t2_data");
    obi_wr(CTRL_OFFSET, 32'h2);
    stat("t2_clr", 32'h1);
`else
    fork
      begin
        axi_aw(4'd2, 8'd9);
        for (int i = 0; i < 10; i++)
          axi_w(32'hB0 + i, i == 9, 1'b1);
        axi_b(4'd2, RESP_OKAY);
      end
      begin : t2_reader
        int n;
        n = 0;
        while (!full && n < 200) begin
          @(negedge clk); n++;
        end
        check("t2_full", full, 1);
        check("t2_wready", axi_rsp.w_ready, 0);
        obi_pop("t2_pop");
        obi_pop("t2_pop");
      end
    join
    stat("t2_status", 32'h802);
    for (int i = 0; i < 8; i++) obi_pop("t2_data");
    check("t2_empty", empty, 1);
`endif

    obi_wr(THRESH_OFFSET, 32'h4);
    obi_rd(THRESH_OFFSET, d);
    check("t3_thresh", d, 32'h4);
    axi_aw(4'd3, 8'd3);
    for (int i = 0; i < 3; i++)
      axi_w(32'hC0 + i, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t3_irq_cnt3", irq, 0);
    axi_w(32'hC3, 1'b1, 1'b1);
    @(negedge clk);
    check("t3_irq_lag", irq, 0);
    @(negedge clk);
    check("t3_irq_cnt4", irq, 1);
    axi_b(4'd3, RESP_OKAY);
    obi_pop("t3_data");
    check("t3_irq_pop_lag", irq, 1);
    @(negedge clk);
    check("t3_irq_cnt3b", irq, 0);
    for (int i = 0; i < 3; i++) obi_pop("t3_data");
    obi_wr(THRESH_OFFSET, 32'h0);

    obi_pop("t4_empty_rd");
    stat("t4_udf", 32'h9);
    obi_wr(CTRL_OFFSET, 32'h2);
    stat("t4_clr", 32'h1);

    axi_aw(4'd4, 8'd5);
    for (int i = 0; i < 5; i++)
      axi_w(32'hD0 + i, 1'b0, 1'b1);
    stat("t5_pre", 32'h500);
    fork
      axi_w(32'hD5, 1'b1, 1'b0);
      obi_wr(CTRL_OFFSET, 32'h1);
    join
    q.delete();
    axi_b(4'd4, RESP_OKAY);
    stat("t5_status", 32'h1);
    check("t5_empty", empty, 1);

    fork
      begin : t6_reader
        int n;
        @(negedge clk);
        axi_req.ar       = '0;
        axi_req.ar.id    = 4'd5;
        axi_req.ar.len   = 8'd1;
        axi_req.ar_valid = 1'b1;
        n = 0;
        while (!axi_rsp.ar_ready && n < 100) begin
          @(negedge clk); n++;
        end
        @(posedge clk); #1;
        axi_req.ar_valid = 1'b0;
        axi_req.r_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          n = 0;
          while (!axi_rsp.r_valid && n < 100) begin
            @(negedge clk); n++;
          end
          check("t6_rvalid", axi_rsp.r_valid, 1);
          check("t6_rdata", axi_rsp.r.data, 0);
          check("t6_rresp", axi_rsp.r.resp, RESP_SLVERR);
          check("t6_rid", axi_rsp.r.id, 5);
          check("t6_rlast", axi_rsp.r.last, i == 1);
          @(posedge clk); #1;
        end
        axi_req.r_ready = 1'b0;
        @(negedge clk);
        check("t6_ar_idle", axi_rsp.ar_ready, 1);
      end
      begin
        axi_aw(4'd6, 8'd1);
        axi_w(32'hE0, 1'b0, 1'b1);
        axi_w(32'hE1, 1'b1, 1'b1);
        axi_b(4'd6, RESP_OKAY);
      end
    join
    obi_pop("t6_data");
    obi_pop("t6_data");
    check("t6_empty", empty, 1);

    axi_aw(4'd7, 8'd3);
    axi_w(32'hF0, 1'b0, 1'b1);
    axi_w(32'hF1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t7_empty", empty, 1);
    check("t7_aw_ready", axi_rsp.aw_ready, 1);
    check("t7_w_ready", axi_rsp.w_ready, 0);
    rst = 1'b0;
    q.delete();
    stat("t7_status", 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
